// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with prefetch FIFO and multiple outstanding bus requests
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h8000_0000
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_prefetch #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_ADDR      = `CPU_RESET_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        stall_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    output logic        inst_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   resp_pc_q, resp_pc_d;

    logic [CW-1:0] live;
    logic          credit_ok;
    logic          out_ok;
    logic [31:0]   flush_aligned;
    logic          fire;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          fifo_ne;
    entry_t        head;

    // Live requests are those whose responses will land in the FIFO; together
    // with buffered entries they must never exceed the FIFO depth.
    always_comb begin
        live          = out_cnt_q - drop_cnt_q;
        credit_ok     = ({1'b0, live} + {1'b0, count_q}) < DEPTH_C;
        out_ok        = out_cnt_q < MAXO_C;
        flush_aligned = flush_addr_i & 32'hFFFF_FFFC;
        instr_req_o   = rst_n & out_ok & (flush_i | credit_ok);
        instr_addr_o  = flush_i ? flush_aligned : fetch_addr_q;
        fire          = instr_req_o & instr_gnt_i;
        rsp           = instr_rvalid_i & (out_cnt_q != '0);
        push          = rsp & (drop_cnt_q == '0) & ~flush_i;
        fifo_ne       = count_q != '0;
        inst_valid_o  = fifo_ne & ~flush_i;
        pop           = inst_valid_o & ~stall_i;
        head          = mem_q[rd_ptr_q];
        inst_o        = inst_valid_o ? head.inst : `INST_NOP;
        inst_err_o    = inst_valid_o & head.err;
        pc_o          = fifo_ne ? head.pc : resp_pc_q;
    end

    always_comb begin
        out_cnt_d    = out_cnt_q + CW'(fire) - CW'(rsp);
        drop_cnt_d   = drop_cnt_q;
        fetch_addr_d = fetch_addr_q;
        resp_pc_d    = resp_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        if (fire) begin
            fetch_addr_d = instr_addr_o + 32'd4;
        end else if (flush_i) begin
            fetch_addr_d = flush_aligned;
        end
        if (flush_i) begin
            // Everything already in flight belongs to the old stream, including
            // a response arriving right now; a same-cycle grant is the new head.
            drop_cnt_d = out_cnt_q - CW'(rsp);
            resp_pc_d  = flush_aligned;
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
        end else begin
            if (rsp && drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            out_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            fetch_addr_q <= RESET_ADDR & 32'hFFFF_FFFC;
            resp_pc_q    <= RESET_ADDR & 32'hFFFF_FFFC;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            out_cnt_q    <= out_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            fetch_addr_q <= fetch_addr_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

    // Payload storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{err: instr_err_i, pc: resp_pc_q, inst: instr_rdata_i};
        end
    end

    a_rvalid_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
        instr_rvalid_i |-> (out_cnt_q != '0));

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push & ~pop) |-> ({1'b0, count_q} < DEPTH_C));

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - randomized self-checking bench for ifu_prefetch against a sequential-stream model
module tb_ifu_prefetch;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RST_A = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk, rst_n, flush_i, stall_i;
    logic [31:0] flush_addr_i, inst_o, pc_o, instr_addr_o, instr_rdata_i;
    logic        inst_valid_o, inst_err_o, instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;

    ifu_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_ADDR(RST_A)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .stall_i(stall_i), .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o),
        .inst_err_o(inst_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_addr_o(instr_addr_o),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ready; } pend_t;
    pend_t       pq[$];
    int          n_checks = 0, n_errors = 0;
    int          cyc = 0, n_deliv = 0;
    int          gnt_mode, stall_mode, lat_min, lat_max;
    bit          rv_random, err_rand;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] exp_pc, exp_req, prev_fire_addr;
    bit          last_req, last_fire, last_rv, last_valid, last_deliv, last_err, wrap_seen;
    logic [31:0] last_pc, last_addr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic err_fn(input logic [31:0] a);
        return (a == err_addr) || (err_rand && a[6:2] == 5'h13);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive inputs on the falling edge, check outputs, update the model.
    task automatic step(input bit do_flush, input logic [31:0] faddr);
        bit g;
        @(negedge clk);
        flush_i      = do_flush;
        flush_addr_i = faddr;
        case (stall_mode)
            0:       stall_i = 1'b0;
            1:       stall_i = 1'b1;
            default: stall_i = ($urandom_range(0, 2) == 0);
        endcase
        last_rv = 0;
        if (pq.size() != 0 && pq[0].ready <= cyc && (!rv_random || $urandom_range(0, 3) != 0)) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_fn(pq[0].addr);
            instr_err_i    = err_fn(pq[0].addr);
            void'(pq.pop_front());
            last_rv = 1;
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
            instr_err_i    = 1'($urandom_range(0, 1));
        end
        #1;
        last_valid = inst_valid_o;
        last_req   = instr_req_o;
        last_addr  = instr_addr_o;
        last_pc    = pc_o;
        last_err   = inst_err_o;
        last_deliv = 0;
        if (do_flush) check_eq("flush_masks_valid", inst_valid_o, 0);
        if (inst_valid_o) begin
            check_eq("head_pc", pc_o, exp_pc);
            check_eq("head_inst", inst_o, mem_fn(exp_pc));
            check_eq("head_err", inst_err_o, err_fn(exp_pc));
            if (!stall_i) begin
                last_deliv = 1;
                n_deliv++;
                exp_pc += 32'd4;
            end
        end else begin
            check_eq("idle_inst", inst_o, NOP);
            check_eq("idle_err", inst_err_o, 0);
            if (!do_flush) check_eq("idle_pc", pc_o, exp_pc);
        end
        if (do_flush) begin
            exp_pc  = faddr & 32'hFFFF_FFFC;
            exp_req = faddr & 32'hFFFF_FFFC;
        end
        g = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
        instr_gnt_i = g;
        last_fire = 0;
        if (instr_req_o) begin
            check_eq("req_addr", instr_addr_o, exp_req);
            if (g) begin
                pq.push_back('{addr: instr_addr_o, ready: cyc + int'($urandom_range(lat_min, lat_max))});
                last_fire = 1;
                if (instr_addr_o == 32'h0 && prev_fire_addr == 32'hFFFF_FFFC) wrap_seen = 1;
                prev_fire_addr = instr_addr_o;
                exp_req += 32'd4;
                check_eq("outstanding_max", pq.size() <= MAXO, 1);
            end
        end
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fire_cyc, deliv_cyc, cnt;
        bit found;
        logic [7:0] pattern;
        rst_n = 0; flush_i = 0; flush_addr_i = 0; stall_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
        gnt_mode = 1; stall_mode = 0; rv_random = 0; err_rand = 0; lat_min = 1; lat_max = 1;
        exp_pc = RST_A; exp_req = RST_A; prev_fire_addr = 0; wrap_seen = 0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req", instr_req_o, 0);
        check_eq("rst_valid", inst_valid_o, 0);
        check_eq("rst_err", inst_err_o, 0);
        check_eq("rst_inst", inst_o, NOP);
        check_eq("rst_pc", pc_o, RST_A);
        @(negedge clk);
        rst_n = 1;

        // Startup stream: first delivery two cycles after first grant, then one per cycle
        fire_cyc = -1; deliv_cyc = -1; cnt = 0;
        repeat (12) begin
            step(0, 0);
            if (last_fire && fire_cyc < 0) fire_cyc = cyc - 1;
            if (last_deliv) begin
                if (deliv_cyc < 0) deliv_cyc = cyc - 1;
                cnt++;
            end
        end
        check_eq("first_latency", 32'(deliv_cyc - fire_cyc), 2);
        check_eq("stream_rate", cnt, 10);

        // Held stall fills exactly DEPTH entries, then they drain back to back
        stall_mode = 1;
        repeat (10) step(0, 0);
        check_eq("stall_req_off", last_req, 0);
        check_eq("stall_valid", last_valid, 1);
        stall_mode = 0; gnt_mode = 0; pattern = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            pattern[i] = last_deliv;
        end
        check_eq("stall_drain", pattern, 8'b0000_1111);

        // Flush with two requests in flight
        gnt_mode = 1; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && pq.size() != 2; i++) step(0, 0);
        check_eq("two_in_flight", pq.size(), 2);
        step(1, 32'h8000_0100);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0);
            found = last_deliv;
        end
        check_eq("flush2_found", found, 1);
        check_eq("flush2_first_pc", last_pc, 32'h8000_0100);

        // Flush coinciding with a response and a grant
        lat_min = 1; lat_max = 1;
        repeat (6) step(0, 0);
        step(1, 32'h8000_0200);
        check_eq("flush_rv_gnt", {last_rv, last_fire}, 2'b11);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0);
            found = last_deliv;
        end
        check_eq("flush3_found", found, 1);
        check_eq("flush3_first_pc", last_pc, 32'h8000_0200);

        // Bus withholds grant, then an error response in a sequential stream
        gnt_mode = 0;
        for (int i = 0; i < 12 && (pq.size() != 0 || last_valid); i++) step(0, 0);
        step(1, 32'h8000_0000);
        repeat (5) begin
            step(0, 0);
            check_eq("nognt_valid", last_valid, 0);
            check_eq("nognt_req", last_req, 1);
            check_eq("nognt_addr", last_addr, 32'h8000_0000);
        end
        err_addr = 32'h8000_0008; gnt_mode = 1; cnt = 0;
        repeat (12) begin
            step(0, 0);
            if (last_deliv && last_err) begin
                cnt++;
                check_eq("err_pc", last_pc, 32'h8000_0008);
            end
        end
        check_eq("err_count", cnt, 1);

        // Address wrap at the top of the space
        wrap_seen = 0;
        step(1, 32'hFFFF_FFF8);
        repeat (10) step(0, 0);
        check_eq("addr_wrap", wrap_seen, 1);

        // Asynchronous reset mid-burst; late response during reset is ignored
        lat_min = 2; lat_max = 2;
        repeat (4) step(0, 0);
        @(negedge clk);
        instr_rvalid_i = 0; instr_gnt_i = 0; flush_i = 0;
        #3 rst_n = 0;
        #1;
        check_eq("arst_req", instr_req_o, 0);
        check_eq("arst_valid", inst_valid_o, 0);
        check_eq("arst_err", inst_err_o, 0);
        check_eq("arst_inst", inst_o, NOP);
        check_eq("arst_pc", pc_o, RST_A);
        @(negedge clk);
        instr_rvalid_i = 1; instr_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        instr_rvalid_i = 0;
        pq.delete();
        exp_pc = RST_A; exp_req = RST_A;
        rst_n = 1;
        lat_min = 1; lat_max = 1; found = 0;
        repeat (20) begin
            step(0, 0);
            if (last_deliv && !found) begin
                found = 1;
                check_eq("arst_first_pc", last_pc, RST_A);
            end
        end
        check_eq("arst_found", found, 1);

        // Randomized traffic: grants, latency, stalls and flushes
        gnt_mode = 2; stall_mode = 2; rv_random = 1; lat_min = 1; lat_max = 4;
        step(1, $urandom);
        err_rand = 1;
        cnt = n_deliv;
        repeat (1500) begin
            logic [31:0] fa;
            fa = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 29) == 0, fa);
        end
        check_eq("random_progress", (n_deliv - cnt) > 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
